pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have the parameter PC_W, default 6, giving the program counter width.
REQ-002 The port clock SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-004 The port run SHALL be an input, 1 bit wide, and enables free-running execution when high.
REQ-005 The port step SHALL be an input, 1 bit wide, and is a single-cycle pulse requesting one advance while paused.
REQ-006 The port halt SHALL be an input, 1 bit wide, and requests a sticky stop.
REQ-007 The port c_pc SHALL be an input, 1 bit wide, and is the control word bit permitting a PC update this cycle.
REQ-008 The port c_br SHALL be an input, 1 bit wide, and marks the current instruction as a branch.
REQ-009 The port cond SHALL be an input, 3 bits wide, and carries the branch condition code.
REQ-010 The port offset SHALL be an input, PC_W bits wide, and is a two's-complement branch displacement.
REQ-011 The port flag_reg SHALL be an input, 4 bits wide, driven from the flags register: [0]=C, [1]=Z, [2]=N, [3]=O.
REQ-012 The port pc SHALL be an output, PC_W bits wide, and is the registered program counter.
REQ-013 The port taken SHALL be an output, 1 bit wide, and is a registered pulse high for one cycle after a taken branch.
REQ-014 The port state SHALL be an output, 2 bits wide, and is the current state encoding.

Function
REQ-015 States SHALL be RUN=2'b00, PAUSED=2'b01 and HALTED=2'b10; 2'b11 is illegal and SHALL recover to PAUSED on the next clock.
REQ-016 Transitions: RUN->PAUSED when run=0; PAUSED->RUN when run=1; RUN or PAUSED->HALTED when halt=1; HALTED SHALL be left only by reset.
REQ-017 halt SHALL have priority over run and step; the cycle in which halt=1 is sampled SHALL NOT update pc.
REQ-018 adv = c_pc AND ((state==RUN AND run) OR (state==PAUSED AND step)) AND NOT halt; pc and taken SHALL change only when adv=1.
REQ-019 Condition decode (cond): 000 always; 001 Z; 010 !Z; 011 !Z & (N==O); 100 N==O; 101 N!=O; 110 Z | (N!=O); 111 never.
REQ-020 On adv with c_br=1 and the condition true, pc SHALL become pc+1+offset (sign-extended offset), computed modulo 2^PC_W.
REQ-021 On adv otherwise, pc SHALL become pc+1 modulo 2^PC_W; at pc=2^PC_W-1 it SHALL wrap to 0.
REQ-022 taken SHALL be 1 in the cycle after an adv with a taken branch, and 0 in every other cycle.
REQ-023 flag_reg SHALL be sampled combinationally in the adv cycle, so a flag written in the same edge is not seen until the following cycle.
REQ-024 A step pulse while in RUN or HALTED SHALL be ignored; a step lasting N cycles in PAUSED SHALL cause N advances, each gated by c_pc.

Reset
REQ-025 When reset=1 at a clock edge: pc=0, taken=0, state=PAUSED, regardless of every other input, including during HALTED.
REQ-026 Reset SHALL take priority over halt, run and step in the same cycle.

Structure
REQ-027 A shared package SHALL hold the state encodings, the cond encodings (COND_JMP..COND_NEV) and the flag bit index constants C_BIT, Z_BIT, N_BIT and O_BIT.
REQ-028 One combinational sub-module branch_cond (cond, flag_reg -> cond_true) SHALL contain the condition decode; the state register, pc and taken SHALL live in pc_branch_unit.

Verification
REQ-029 Reset, then hold run=1 and c_pc=1 with c_br=0 for 64 cycles -> pc counts 0..63 and wraps to 0, with taken=0 throughout.
REQ-030 With pc=10, c_br=1, cond=001, flag_reg=4'b0010 (Z=1) and offset=6'b111100 (-4) -> pc=7 and taken=1 for exactly one cycle; the same stimulus with Z=0 -> pc=11 and taken=0.
REQ-031 Sweep all 8 cond values against all 16 flag_reg values with offset=+3 from pc=20 -> pc=24 when the REQ-019 condition is true, else pc=21.
REQ-032 Drive run=0 with state=PAUSED, then three step pulses with c_pc=1 from pc=5 -> pc=8, with no change between pulses.
REQ-033 Assert halt together with run=1 and c_pc=1 at pc=30 -> pc stays 30, state=HALTED, and run/step are then ignored for 10 cycles; assert reset -> pc=0 and state=PAUSED.
REQ-034 Assert reset together with halt and a taken branch -> the next-cycle values are pc=0, taken=0 and state=PAUSED.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// pc_branch_unit_pkg: state, condition-code and flag-bit encodings shared by the PC/branch unit
package pc_branch_unit_pkg;
  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_PAUSED  = 2'b01;
  localparam logic [1:0] ST_HALTED  = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;
  localparam logic [2:0] COND_JMP = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_NE  = 3'b010;
  localparam logic [2:0] COND_GT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LT  = 3'b101;
  localparam logic [2:0] COND_LE  = 3'b110;
  localparam logic [2:0] COND_NEV = 3'b111;
  localparam int C_BIT = 0;
  localparam int Z_BIT = 1;
  localparam int N_BIT = 2;
  localparam int O_BIT = 3;
endpackage

// File: rtl/pc_branch_unit_branch_cond.sv
// branch_cond: decodes cond against flag_reg {O,N,Z,C} into cond_true (purely combinational)
module branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flag_reg,
  output logic       cond_true
);
  logic z, lt, unused_c;
  always_comb begin
    unused_c  = flag_reg[C_BIT];
    z         = flag_reg[Z_BIT];
    lt        = flag_reg[N_BIT] ^ flag_reg[O_BIT];
    cond_true = cond == COND_JMP ? 1'b1 :
                cond == COND_EQ  ? z :
                cond == COND_NE  ? ~z :
                cond == COND_GT  ? ~z & ~lt :
                cond == COND_GE  ? ~lt :
                cond == COND_LT  ? lt :
                cond == COND_LE  ? z | lt : 1'b0;
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: run/pause/halt FSM with PC increment/branch; in clock,reset,run,step,halt,c_pc,c_br,cond,offset,flag_reg; out pc,taken,state
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            halt,
  input  logic            c_pc,
  input  logic            c_br,
  input  logic [2:0]      cond,
  input  logic [PC_W-1:0] offset,
  input  logic [3:0]      flag_reg,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic [1:0]      state
);
  logic [1:0] state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic taken_q, taken_d, cond_true, adv;
  branch_cond u_cond (
    .cond     (cond),
    .flag_reg (flag_reg),
    .cond_true(cond_true)
  );
  always_comb begin
    adv     = c_pc & ~halt & ((state_q == ST_RUN & run) | (state_q == ST_PAUSED & step));
    taken_d = adv & c_br & cond_true;
    pc_d    = adv ? pc_q + PC_W'(1) + (taken_d ? offset : '0) : pc_q;
    state_d = state_q == ST_HALTED  ? ST_HALTED :
              state_q == ST_ILLEGAL ? ST_PAUSED :
              halt ? ST_HALTED : run ? ST_RUN : ST_PAUSED;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_PAUSED;
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end
  assign pc    = pc_q;
  assign taken = taken_q;
  assign state = state_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed and randomized checks of pc_branch_unit against a behavioural model
module tb_pc_branch_unit;
  localparam int PC_W = 6;
  localparam int M = 1 << PC_W;
  logic clock = 1'b0;
  logic reset, run, step, halt, c_pc, c_br;
  logic [2:0] cond;
  logic [PC_W-1:0] offset;
  logic [3:0] flag_reg;
  logic [PC_W-1:0] pc;
  logic taken;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int m_pc, m_st, m_d;
  bit m_tk, m_adv, m_valid = 1'b0;
  logic [15:0] masks [8];
  pc_branch_unit #(.PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .halt(halt),
    .c_pc(c_pc), .c_br(c_br), .cond(cond), .offset(offset), .flag_reg(flag_reg),
    .pc(pc), .taken(taken), .state(state)
  );
  always #5 clock = ~clock;
  function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
    bit z, n, o;
    z = f[1];
    n = f[2];
    o = f[3];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !z && (n == o);
      3'd4: return n == o;
      3'd5: return n != o;
      3'd6: return z || (n != o);
      default: return 1'b0;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      m_pc = 0;
      m_st = 1;
      m_tk = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_adv = c_pc && !halt && ((m_st == 0 && run) || (m_st == 1 && step));
      m_tk = m_adv && c_br && cond_ok(cond, flag_reg);
      m_d = offset[PC_W-1] ? int'(offset) - M : int'(offset);
      if (m_adv) m_pc = ((m_pc + 1 + (m_tk ? m_d : 0)) % M + M) % M;
      if (m_st != 2) m_st = halt ? 2 : run ? 0 : 1;
    end
  end
  always @(negedge clock) begin
    if (m_valid) begin
      check("model_pc", 32'(pc), 32'(m_pc));
      check("model_taken", 32'(taken), 32'(m_tk));
      check("model_state", 32'(state), 32'(m_st));
    end
  end
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic idle;
    run = 0; step = 0; halt = 0; c_pc = 0; c_br = 0; cond = 0; offset = 0; flag_reg = 0;
  endtask
  task automatic goto_pc(input int v);
    idle();
    reset = 1;
    tick();
    reset = 0;
    step = 1;
    c_pc = 1;
    repeat (v) tick();
    step = 0;
    c_pc = 0;
  endtask
  initial begin
    masks[0] = 16'hFFFF; masks[1] = 16'hCCCC; masks[2] = 16'h3333; masks[3] = 16'h3003;
    masks[4] = 16'hF00F; masks[5] = 16'h0FF0; masks[6] = 16'hCFFC; masks[7] = 16'h0000;
    idle();
    reset = 1;
    tick();
    tick();
    check("reset_pc", 32'(pc), 0);
    check("reset_state", 32'(state), 1);
    check("reset_taken", 32'(taken), 0);
    reset = 0;
    run = 1;
    c_pc = 1;
    tick();
    check("enter_run_state", 32'(state), 0);
    check("enter_run_pc", 32'(pc), 0);
    for (int i = 0; i < 64; i++) begin
      tick();
      check("count_pc", 32'(pc), 32'((i + 1) % 64));
      check("count_taken", 32'(taken), 0);
    end
    check("wrap_pc", 32'(pc), 0);
    goto_pc(10);
    c_br = 1; cond = 3'b001; flag_reg = 4'b0010; offset = 6'b111100; step = 1; c_pc = 1;
    tick();
    check("br_taken_pc", 32'(pc), 7);
    check("br_taken_pulse", 32'(taken), 1);
    idle();
    tick();
    check("br_taken_drop", 32'(taken), 0);
    check("br_taken_hold", 32'(pc), 7);
    goto_pc(10);
    c_br = 1; cond = 3'b001; flag_reg = 4'b0000; offset = 6'b111100; step = 1; c_pc = 1;
    tick();
    check("br_not_pc", 32'(pc), 11);
    check("br_not_taken", 32'(taken), 0);
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        goto_pc(20);
        c_br = 1; cond = 3'(c); flag_reg = 4'(f); offset = 6'd3; step = 1; c_pc = 1;
        tick();
        check($sformatf("sweep_c%0d_f%0d", c, f), 32'(pc), masks[c][f] ? 24 : 21);
        idle();
      end
    end
    goto_pc(5);
    for (int k = 0; k < 3; k++) begin
      step = 1;
      c_pc = 1;
      tick();
      check("step_pc", 32'(pc), 32'(6 + k));
      step = 0;
      tick();
      tick();
      check("step_gap_pc", 32'(pc), 32'(6 + k));
    end
    goto_pc(30);
    halt = 1; run = 1; c_pc = 1;
    tick();
    check("halt_pc", 32'(pc), 30);
    check("halt_state", 32'(state), 2);
    halt = 0;
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom);
      step = 1'($urandom);
      tick();
      check("halted_pc", 32'(pc), 30);
      check("halted_state", 32'(state), 2);
    end
    reset = 1;
    tick();
    check("halt_reset_pc", 32'(pc), 0);
    check("halt_reset_state", 32'(state), 1);
    idle();
    reset = 0;
    run = 1;
    c_pc = 1;
    tick();
    tick();
    check("pre_rst_pc", 32'(pc), 1);
    reset = 1; halt = 1; c_br = 1; cond = 3'b000; offset = 6'd5;
    tick();
    check("rst_prio_pc", 32'(pc), 0);
    check("rst_prio_taken", 32'(taken), 0);
    check("rst_prio_state", 32'(state), 1);
    reset = 0;
    idle();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 50) == 0;
      halt = ($urandom % 40) == 0;
      run = ($urandom % 4) != 0;
      step = 1'($urandom);
      c_pc = ($urandom % 5) != 0;
      c_br = 1'($urandom);
      cond = 3'($urandom);
      offset = PC_W'($urandom);
      flag_reg = 4'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
